// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED/BNC driver with prescaled tick, OFF/ON/BLINK/COUNT modes.
// Define LED_PWM_EN to add per-channel PWM duty dimming; otherwise cfg_duty is ignored.
module led_pattern_gen #(
    parameter int N_CH     = 4,
    parameter int DIV      = 200_000_000,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_in,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic                tick,
    output logic [N_CH-1:0]     leds,
    output logic [N_CH-1:0]     bnc
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [1:0] MODE_OFF = 2'd0, MODE_ON = 2'd1, MODE_BLINK = 2'd2;

    logic [PW-1:0]   r_pre;
    logic            r_tick;
    logic [N_CH-1:0] r_tcnt, r_phase, r_leds, r_bnc;
    logic [1:0]      r_mode [N_CH];
    logic [N_CH-1:0] w_wr, w_raw, w_gate;

    always_ff @(posedge clk or posedge rst_in)
        if (rst_in) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
            r_tcnt <= '0;
        end else begin
            r_pre  <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
            r_tick <= r_pre == PRE_MAX;
            if (r_tick)
                r_tcnt <= r_tcnt + 1'b1;
        end

    // Out-of-range channel indices simply match no decode line.
    always_comb begin
        w_wr  = '0;
        w_raw = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_wr[i]  = cfg_we && cfg_ch == 4'(i);
            w_raw[i] = (r_mode[i] == MODE_OFF)   ? 1'b0 :
                       (r_mode[i] == MODE_ON)    ? 1'b1 :
                       (r_mode[i] == MODE_BLINK) ? r_phase[i] : r_tcnt[i];
        end
    end

    // A write forces the blink phase high, taking priority over a same-cycle toggle.
    always_ff @(posedge clk or posedge rst_in)
        if (rst_in) begin
            for (int i = 0; i < N_CH; i++)
                r_mode[i] <= MODE_OFF;
            r_phase <= '0;
        end else
            for (int i = 0; i < N_CH; i++) begin
                if (w_wr[i])
                    r_mode[i] <= cfg_mode;
                r_phase[i] <= w_wr[i] | (r_phase[i] ^ r_tick);
            end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] r_pwm;
    logic [PWM_BITS-1:0] r_duty [N_CH];

    always_ff @(posedge clk or posedge rst_in)
        if (rst_in) begin
            r_pwm <= '0;
            for (int i = 0; i < N_CH; i++)
                r_duty[i] <= '1;
        end else begin
            r_pwm <= r_pwm + 1'b1;
            for (int i = 0; i < N_CH; i++)
                if (w_wr[i])
                    r_duty[i] <= cfg_duty;
        end

    always_comb begin
        w_gate = '0;
        for (int i = 0; i < N_CH; i++)
            w_gate[i] = (r_duty[i] == '0) ? 1'b0 : (&r_duty[i]) ? 1'b1 : (r_pwm < r_duty[i]);
    end
`else
    logic w_unused_duty;
    assign w_unused_duty = ^cfg_duty;
    assign w_gate        = '1;
`endif

    always_ff @(posedge clk or posedge rst_in)
        if (rst_in) begin
            r_leds <= '1;
            r_bnc  <= '1;
        end else begin
            r_leds <= ~(w_raw & w_gate);
            r_bnc  <= ~(w_raw & w_gate);
        end

    assign tick = r_tick;
    assign leds = r_leds;
    assign bnc  = r_bnc;
endmodule
